// File: rtl/spi_slave_regfile_if.sv
// SPI slave pin bundle plus register-file / strobe outputs.
// Latency: none (wires only).
// Backpressure: none; the SPI master owns timing through SCLK and CS.
// Ports: slave modport = SPI pins in, MISO/regs/strobes out; master modport is the mirror.
interface spi_slave_regfile_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
);
    logic                              ena;
    logic                              cpol;
    logic                              cpha;
    logic                              spi_sclk;
    logic                              spi_cs_n;
    logic                              spi_mosi;
    logic                              spi_miso;
    logic                              spi_miso_oe;
    logic [DATA_W*(2**ADDR_W)-1:0]     regs_o;
    logic                              wr_valid;
    logic [ADDR_W-1:0]                 wr_addr;
    logic                              frame_err;
    logic                              busy;

    modport slave (
        input  ena, cpol, cpha, spi_sclk, spi_cs_n, spi_mosi,
        output spi_miso, spi_miso_oe, regs_o, wr_valid, wr_addr, frame_err, busy
    );

    modport master (
        output ena, cpol, cpha, spi_sclk, spi_cs_n, spi_mosi,
        input  spi_miso, spi_miso_oe, regs_o, wr_valid, wr_addr, frame_err, busy
    );
endinterface

// File: rtl/spi_slave_regfile.sv
// SPI slave (all CPOL/CPHA modes) with a burst read/write register file, oversampled in clk.
// Latency: pin to action SYNC_STAGES+1 clk; write strobe one clk after the completing sample edge.
// Backpressure: none; every SPI word is accepted, a partial word at CS rise is dropped with frame_err.
// Ports: clk, rst_n (async active low); bus = slave modport of spi_slave_regfile_if.
module spi_slave_regfile #(
    parameter int DATA_W      = 8,
    parameter int ADDR_W      = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    spi_slave_regfile_if.slave     bus
);
    localparam int DEPTH = 2**ADDR_W;
    localparam int CNT_W = (DATA_W > 2) ? $clog2(DATA_W) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CMD   = 2'd1,
        S_WRITE = 2'd2,
        S_READ  = 2'd3
    } state_t;

    // ---------------- pin synchronisers ----------------
    logic [SYNC_STAGES-1:0] r_sclk_sync;
    logic [SYNC_STAGES-1:0] r_csn_sync;
    logic [SYNC_STAGES-1:0] r_mosi_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sclk_sync <= '0;
            r_csn_sync  <= '1;   // idle = deselected, so release never fakes a CS fall
            r_mosi_sync <= '0;
        end else begin
            r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], bus.spi_sclk};
            r_csn_sync  <= {r_csn_sync[SYNC_STAGES-2:0],  bus.spi_cs_n};
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], bus.spi_mosi};
        end
    end

    // ---------------- state ----------------
    state_t              r_state;
    logic                r_sclk_d;
    logic                r_csn_d;
    logic                r_cpol;
    logic                r_cpha;
    logic [CNT_W-1:0]    r_bit_cnt;
    logic [DATA_W-2:0]   r_rx_sr;
    logic [DATA_W-1:0]   r_tx_sr;
    logic [ADDR_W-1:0]   r_ptr;
    logic [DATA_W-1:0]   r_regs [DEPTH];
    logic                r_wr_valid;
    logic [ADDR_W-1:0]   r_wr_addr;
    logic                r_frame_err;

    // ---------------- edge decode ----------------
    logic              w_sclk_s;
    logic              w_mosi_s;
    logic              w_csn_eff;
    logic              w_cs_fall;
    logic              w_sclk_rise;
    logic              w_sclk_fall;
    logic              w_lead;
    logic              w_trail;
    logic              w_sample;
    logic              w_shift;
    logic              w_last_bit;
    logic [DATA_W-1:0] w_rx_word;
    logic [DATA_W-1:0] w_load_val;

    assign w_sclk_s    = r_sclk_sync[SYNC_STAGES-1];
    assign w_mosi_s    = r_mosi_sync[SYNC_STAGES-1];
    // Disabling the block looks exactly like the master deselecting it.
    assign w_csn_eff   = r_csn_sync[SYNC_STAGES-1] | ~bus.ena;
    assign w_cs_fall   = r_csn_d & ~w_csn_eff;
    assign w_sclk_rise = w_sclk_s & ~r_sclk_d;
    assign w_sclk_fall = ~w_sclk_s & r_sclk_d;
    // Leading edge moves SCLK away from its idle level.
    assign w_lead      = r_cpol ? w_sclk_fall : w_sclk_rise;
    assign w_trail     = r_cpol ? w_sclk_rise : w_sclk_fall;
    assign w_sample    = r_cpha ? w_trail : w_lead;
    assign w_shift     = r_cpha ? w_lead  : w_trail;
    assign w_last_bit  = (r_bit_cnt == CNT_W'(DATA_W-1));
    assign w_rx_word   = {r_rx_sr, w_mosi_s};
    assign w_load_val  = (r_state == S_READ) ? r_regs[r_ptr] : '0;

    // ---------------- main FSM ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_sclk_d    <= 1'b0;
            r_csn_d     <= 1'b1;
            r_cpol      <= 1'b0;
            r_cpha      <= 1'b0;
            r_bit_cnt   <= '0;
            r_rx_sr     <= '0;
            r_tx_sr     <= '0;
            r_ptr       <= '0;
            r_wr_valid  <= 1'b0;
            r_wr_addr   <= '0;
            r_frame_err <= 1'b0;
            for (int k = 0; k < DEPTH; k++) begin
                r_regs[k] <= '0;
            end
        end else begin
            r_sclk_d    <= w_sclk_s;
            r_csn_d     <= w_csn_eff;
            r_wr_valid  <= 1'b0;
            r_frame_err <= 1'b0;

            if (r_state == S_IDLE) begin
                if (w_cs_fall) begin
                    r_state   <= S_CMD;
                    r_cpol    <= bus.cpol;
                    r_cpha    <= bus.cpha;
                    r_bit_cnt <= '0;
                    r_rx_sr   <= '0;
                    r_tx_sr   <= '0;     // cpha=0 load: command word returns zeros
                end
            end else if (w_csn_eff) begin
                // End of frame; any half-received word is thrown away.
                r_state   <= S_IDLE;
                r_tx_sr   <= '0;
                r_bit_cnt <= '0;
                if (r_bit_cnt != '0) begin
                    r_frame_err <= 1'b1;
                end
            end else begin
                if (w_sample) begin
                    r_rx_sr <= w_rx_word[DATA_W-2:0];
                    if (w_last_bit) begin
                        r_bit_cnt <= '0;
                        case (r_state)
                            S_CMD: begin
                                r_state <= w_rx_word[DATA_W-1] ? S_WRITE : S_READ;
                                r_ptr   <= w_rx_word[ADDR_W-1:0];
                            end
                            S_WRITE: begin
                                r_regs[r_ptr] <= w_rx_word;
                                r_wr_valid    <= 1'b1;
                                r_wr_addr     <= r_ptr;
                                r_ptr         <= r_ptr + ADDR_W'(1);
                            end
                            default: begin
                                r_ptr <= r_ptr + ADDR_W'(1);
                            end
                        endcase
                    end else begin
                        r_bit_cnt <= r_bit_cnt + CNT_W'(1);
                    end
                end
                // A shift edge seen with bit_cnt==0 is the first shift of a word:
                // for cpha=1 it precedes the first sample, for cpha=0 it follows the
                // previous word's last sample. Either way it is the load point.
                if (w_shift) begin
                    if (r_bit_cnt == '0) begin
                        r_tx_sr <= w_load_val;
                    end else begin
                        r_tx_sr <= {r_tx_sr[DATA_W-2:0], 1'b0};
                    end
                end
            end
        end
    end

    // ---------------- outputs ----------------
    genvar g;
    generate
        for (g = 0; g < DEPTH; g++) begin : g_flat
            assign bus.regs_o[g*DATA_W +: DATA_W] = r_regs[g];
        end
    endgenerate

    // tx_sr is cleared whenever the frame ends, so MISO is 0 in IDLE.
    assign bus.spi_miso    = r_tx_sr[DATA_W-1];
    assign bus.busy        = (r_state != S_IDLE);
    assign bus.spi_miso_oe = (r_state != S_IDLE);
    assign bus.wr_valid    = r_wr_valid;
    assign bus.wr_addr     = r_wr_addr;
    assign bus.frame_err   = r_frame_err;
endmodule
